window_3x3_ctrl: RTL

WINDOW_3X3_CTRL -- requirements
Module: window_3x3_ctrl

---
 rtl/window_3x3_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/window_3x3_ctrl.sv
// 3x3 sliding-window generator for a raster-order 8-bit pixel stream.
// Two line buffers plus three column shift registers form the window; one output stage.
module window_3x3_ctrl #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_pixel,
    output logic       in_ready,
    output logic       win_valid,
    input  logic       out_ready,
    output logic [7:0] w1,
    output logic [7:0] w2,
    output logic [7:0] w3,
    output logic [7:0] w4,
    output logic [7:0] w5,
    output logic [7:0] w6,
    output logic [7:0] w7,
    output logic [7:0] w8,
    output logic [7:0] w9,
    output logic       frame_done,
    output logic [1:0] fsm_state
);

    // Handshake: a pixel is accepted on a rising edge where in_valid && in_ready.
    // The window (w1..w9) is offered while win_valid=1 and consumed on an edge with out_ready=1.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t state, state_next;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [7:0] lb_top [IMG_W];
    logic [7:0] lb_mid [IMG_W];

    logic [7:0] top_sr [3];
    logic [7:0] mid_sr [3];
    logic [7:0] bot_sr [3];

    logic accept;
    logic last_col;
    logic last_row;
    logic qualify;

    assign in_ready = out_ready || !win_valid;
    assign accept   = in_valid && in_ready;
    assign last_col = (col == CW'(IMG_W - 1));
    assign last_row = (row == RW'(IMG_H - 1));
    assign qualify  = accept && (row >= RW'(2)) && (col >= CW'(2));

    // Line buffers are never reset: rows 0/1 of each frame refill them before any window uses them.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_top[col] <= lb_mid[col];
            lb_mid[col] <= in_pixel;
        end
    end

    // The shift registers double as the output stage: they move only on accept,
    // and no accept can happen while a window is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            state     <= IDLE;
            for (int i = 0; i < 3; i++) begin
                top_sr[i] <= 8'd0;
                mid_sr[i] <= 8'd0;
                bot_sr[i] <= 8'd0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                top_sr[2] <= top_sr[1];
                top_sr[1] <= top_sr[0];
                top_sr[0] <= lb_top[col];
                mid_sr[2] <= mid_sr[1];
                mid_sr[1] <= mid_sr[0];
                mid_sr[0] <= lb_mid[col];
                bot_sr[2] <= bot_sr[1];
                bot_sr[1] <= bot_sr[0];
                bot_sr[0] <= in_pixel;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (qualify) begin
                win_valid <= 1'b1;
            end else if (out_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = ACTIVE;
            end
            ACTIVE: begin
                if (accept && last_col && last_row) state_next = DONE;
            end
            DONE: begin
                state_next = accept ? ACTIVE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign frame_done = (state == DONE);
    assign fsm_state  = state;

    assign w1 = top_sr[2];
    assign w2 = top_sr[1];
    assign w3 = top_sr[0];
    assign w4 = mid_sr[2];
    assign w5 = mid_sr[1];
    assign w6 = mid_sr[0];
    assign w7 = bot_sr[2];
    assign w8 = bot_sr[1];
    assign w9 = bot_sr[0];

endmodule
